// File: rtl/rr_pkg.sv
// Shared constants and types for the four-queue round-robin datapath.
package rr_pkg;

  localparam int NQ  = 4;
  localparam int WW  = 3;
  localparam int IDW = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef logic [WW-1:0]  weight_t;
  typedef logic [IDW-1:0] qid_t;

endpackage

// File: rtl/rr_pop_sched_if.sv
// Read-side bundle between the pop scheduler, the FIFOs and the downstream consumer.
interface rr_pop_sched_if;
  import rr_pkg::*;

  logic [NQ*WW-1:0] request;
  logic             load;
  logic [NQ-1:0]    empty;
  logic             ready;
  logic [NQ-1:0]    pop;
  logic [IDW-1:0]   id;
  logic             valid;
  logic             active;

  modport master (
    input  request, load, empty, ready,
    output pop, id, valid, active
  );

  modport slave (
    output request, load, empty, ready,
    input  pop, id, valid, active
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of elig starting at ptr, wrapping mod NQ.
module rr_pick
  import rr_pkg::*;
(
  input  logic [NQ-1:0] elig,
  input  qid_t          ptr,
  output qid_t          sel,
  output logic          any
);

  qid_t idx;

  // Scan from farthest to nearest so the nearest eligible queue wins.
  always_comb begin
    sel = ptr;
    idx = ptr;
    for (int k = NQ - 1; k >= 0; k--) begin
      idx = ptr + qid_t'(k);
      if (elig[idx]) sel = idx;
    end
  end

  assign any = |elig;

endmodule

// File: rtl/rr_pop_sched.sv
// Weighted round-robin pop scheduler: each eligible queue gets up to its weight in pops per turn.
module rr_pop_sched
  import rr_pkg::*;
(
  input  logic           clk,
  input  logic           reset_L,
  rr_pop_sched_if.master bus
);

  state_t        state_reg, state_next;
  weight_t       w_reg [NQ];
  qid_t          ptr_reg, ptr_next;
  weight_t       credit_reg, credit_next;
  qid_t          id_reg;
  weight_t       nc;
  qid_t          sel;
  logic          any;
  logic          do_pop;
  logic [NQ-1:0] elig;

  generate
    for (genvar gi = 0; gi < NQ; gi++) begin : g_q
      assign elig[gi]    = ~bus.empty[gi] & (w_reg[gi] != '0);
      assign bus.pop[gi] = do_pop & (sel == qid_t'(gi));
    end
  endgenerate

  rr_pick u_pick (
    .elig (elig),
    .ptr  (ptr_reg),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    credit_next = credit_reg;
    do_pop      = (state_reg == ST_ACTIVE) & bus.ready & ~bus.load & any;
    // Credit continues only while the turn stays on ptr; a skip restarts the count.
    nc          = (sel == ptr_reg) ? credit_reg + 1'b1 : weight_t'(1);
    case (state_reg)
      ST_IDLE: begin
        if (bus.load) begin
          state_next  = ST_ACTIVE;
          ptr_next    = '0;
          credit_next = '0;
        end
      end
      ST_ACTIVE: begin
        if (bus.load) begin
          ptr_next    = '0;
          credit_next = '0;
        end else if (do_pop) begin
          if (nc == w_reg[sel]) begin
            ptr_next    = sel + 1'b1;
            credit_next = '0;
          end else begin
            ptr_next    = sel;
            credit_next = nc;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      credit_reg <= '0;
      id_reg     <= '0;
      for (int i = 0; i < NQ; i++) w_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      credit_reg <= credit_next;
      if (do_pop) id_reg <= sel;
      if (bus.load) begin
        for (int i = 0; i < NQ; i++) w_reg[i] <= bus.request[i*WW +: WW];
      end
    end
  end

  // id shows the live selection while popping, otherwise the last served queue.
  assign bus.id     = do_pop ? sel : id_reg;
  assign bus.valid  = do_pop;
  assign bus.active = (state_reg == ST_ACTIVE);

endmodule
